// File: rtl/xbar_switch_allocator.sv
// Switch allocator for the router crossbar: per-output round-robin arbitration with
// wormhole locking, same-cycle grants and a registered crossbar select matrix.
module xbar_switch_allocator #(
    parameter int unsigned NUM_PORT     = 6,
    parameter int unsigned LOG_NUM_PORT = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORT-1:0]              reqValid,
    input  logic [NUM_PORT*LOG_NUM_PORT-1:0] reqOutPort,
    input  logic [NUM_PORT-1:0]              reqTail,
    input  logic [NUM_PORT-1:0]              outReady,
    output logic [NUM_PORT-1:0]              grant,
    output logic [NUM_PORT*NUM_PORT-1:0]     allocVector
);

    localparam int unsigned SUM_W = LOG_NUM_PORT + 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    // Flat matrices: w_req_mat/w_win_mat indexed [j*NUM_PORT + i], w_alloc [i*NUM_PORT + j]
    logic [NUM_PORT*NUM_PORT-1:0] w_req_mat;
    logic [NUM_PORT*NUM_PORT-1:0] w_win_mat;
    logic [NUM_PORT*NUM_PORT-1:0] w_alloc;

    for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_in
        for (genvar gj = 0; gj < NUM_PORT; gj++) begin : g_xp
            // Field values >= NUM_PORT never equal any gj, so illegal ports never match
            assign w_req_mat[gj*NUM_PORT+gi] = reqValid[gi] &&
                (reqOutPort[gi*LOG_NUM_PORT +: LOG_NUM_PORT] == LOG_NUM_PORT'(gj));
            assign w_alloc[gi*NUM_PORT+gj] = w_win_mat[gj*NUM_PORT+gi];
        end
        assign grant[gi] = !reset && (|w_alloc[gi*NUM_PORT +: NUM_PORT]);
    end

    for (genvar gj = 0; gj < NUM_PORT; gj++) begin : g_out
        state_t                  r_state, w_state_nxt;
        logic [LOG_NUM_PORT-1:0] r_owner, w_owner_nxt;
        logic [LOG_NUM_PORT-1:0] r_ptr, w_ptr_nxt;
        logic [NUM_PORT-1:0]     w_req;
        logic [NUM_PORT-1:0]     w_win;
        logic                    w_found;
        logic [SUM_W-1:0]        w_sum;
        logic [LOG_NUM_PORT-1:0] w_idx;

        assign w_req = w_req_mat[gj*NUM_PORT +: NUM_PORT];
        assign w_win_mat[gj*NUM_PORT +: NUM_PORT] = w_win;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_owner <= '0;
                r_ptr   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_owner <= w_owner_nxt;
                r_ptr   <= w_ptr_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_owner_nxt = r_owner;
            w_ptr_nxt   = r_ptr;
            w_win       = '0;
            w_found     = 1'b0;
            w_sum       = '0;
            w_idx       = '0;
            case (r_state)
                S_IDLE: begin
                    if (outReady[gj]) begin
                        // Circular scan starting at the priority pointer
                        for (int k = 0; k < NUM_PORT; k++) begin
                            w_sum = SUM_W'(r_ptr) + SUM_W'(k);
                            if (w_sum >= SUM_W'(NUM_PORT))
                                w_sum = w_sum - SUM_W'(NUM_PORT);
                            w_idx = LOG_NUM_PORT'(w_sum);
                            if (!w_found && w_req[w_idx]) begin
                                w_found    = 1'b1;
                                w_win[w_idx] = 1'b1;
                                w_ptr_nxt  = (w_idx == LOG_NUM_PORT'(NUM_PORT - 1)) ?
                                             '0 : w_idx + LOG_NUM_PORT'(1);
                                if (!reqTail[w_idx]) begin
                                    w_state_nxt = S_LOCKED;
                                    w_owner_nxt = w_idx;
                                end
                            end
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_req[r_owner] && outReady[gj]) begin
                        w_win[r_owner] = 1'b1;
                        if (reqTail[r_owner])
                            w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            allocVector <= '0;
        else
            allocVector <= w_alloc;
    end

endmodule

// File: tb/tb_xbar_switch_allocator.sv
// Directed bench for xbar_switch_allocator: a cycle-by-cycle vector table plus
// hand-written sequences for backpressure and reset during a locked packet.
module tb_xbar_switch_allocator;

    localparam int unsigned N = 6;
    localparam int unsigned L = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     reqValid;
    logic [N*L-1:0]   reqOutPort;
    logic [N-1:0]     reqTail;
    logic [N-1:0]     outReady;
    logic [N-1:0]     grant;
    logic [N*N-1:0]   allocVector;

    int checks   = 0;
    int failures = 0;

    xbar_switch_allocator dut (
        .clk         (clk),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqOutPort  (reqOutPort),
        .reqTail     (reqTail),
        .outReady    (outReady),
        .grant       (grant),
        .allocVector (allocVector)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] v;
        logic [N*L-1:0] p;
        logic [N-1:0] t;
        logic [N-1:0] r;
        logic [N-1:0] g;
        logic [N*N-1:0] a;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [N*L-1:0] pk(input int p0, input int p1, input int p2,
                                          input int p3, input int p4, input int p5);
        return {3'(p5), 3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    function automatic logic [N*N-1:0] ab(input int i, input int j);
        logic [N*N-1:0] one;
        one = 36'h1;
        return one << (i*N + j);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [N-1:0] v, input logic [N*L-1:0] p,
                                input logic [N-1:0] t, input logic [N-1:0] r,
                                input logic [N-1:0] g, input logic [N*N-1:0] a);
        vec_t x;
        x.rst = rst; x.v = v; x.p = p; x.t = t; x.r = r; x.g = g; x.a = a;
        return x;
    endfunction

    task automatic check(input string nm, input logic [N*N-1:0] act, input logic [N*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational grant and the allocVector
    // registered at the previous edge, then advance past the next rising edge.
    task automatic step(input string nm, input logic rst, input logic [N-1:0] v,
                        input logic [N*L-1:0] p, input logic [N-1:0] t, input logic [N-1:0] r,
                        input logic [N-1:0] eg, input logic [N*N-1:0] ea);
        reset = rst; reqValid = v; reqOutPort = p; reqTail = t; outReady = r;
        #1;
        check({nm, "_grant"}, 36'(grant), 36'(eg));
        check({nm, "_alloc"}, allocVector, ea);
        @(posedge clk);
        #1;
    endtask

    logic [N*L-1:0] P0, PRR, PWH, PPERM, PBAD, PB, PR;

    initial begin
        P0    = pk(0, 0, 0, 0, 0, 0);
        PRR   = pk(0, 2, 0, 2, 2, 0);
        PWH   = pk(5, 0, 5, 0, 0, 0);
        PPERM = pk(5, 4, 3, 2, 1, 0);
        PBAD  = pk(6, 7, 6, 7, 6, 7);

        // Reset still asserted: requests present but grant forced low
        tbl.push_back(mk(1, 6'h3F, pk(2,2,2,2,2,2), 6'h3F, 6'h3F, 6'h00, '0));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, '0));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, '0));
        // Round robin on output 2 among inputs 1, 3, 4
        tbl.push_back(mk(0, 6'h1A, PRR, 6'h3F, 6'h3F, 6'h02, '0));
        tbl.push_back(mk(0, 6'h1A, PRR, 6'h3F, 6'h3F, 6'h08, ab(1, 2)));
        tbl.push_back(mk(0, 6'h1A, PRR, 6'h3F, 6'h3F, 6'h10, ab(3, 2)));
        tbl.push_back(mk(0, 6'h1A, PRR, 6'h3F, 6'h3F, 6'h02, ab(4, 2)));
        tbl.push_back(mk(0, 6'h1A, PRR, 6'h3F, 6'h3F, 6'h08, ab(1, 2)));
        tbl.push_back(mk(0, 6'h1A, PRR, 6'h3F, 6'h3F, 6'h10, ab(3, 2)));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, ab(4, 2)));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, '0));
        // Wormhole: input 0 holds output 5 for four flits, input 2 waits
        tbl.push_back(mk(0, 6'h05, PWH, 6'h04, 6'h3F, 6'h01, '0));
        tbl.push_back(mk(0, 6'h05, PWH, 6'h04, 6'h3F, 6'h01, ab(0, 5)));
        tbl.push_back(mk(0, 6'h05, PWH, 6'h04, 6'h3F, 6'h01, ab(0, 5)));
        tbl.push_back(mk(0, 6'h05, PWH, 6'h05, 6'h3F, 6'h01, ab(0, 5)));
        tbl.push_back(mk(0, 6'h04, PWH, 6'h04, 6'h3F, 6'h04, ab(0, 5)));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, ab(2, 5)));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, '0));
        // Full permutation: every output granted in one cycle
        tbl.push_back(mk(0, 6'h3F, PPERM, 6'h3F, 6'h3F, 6'h3F, '0));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00,
                         ab(0,5) | ab(1,4) | ab(2,3) | ab(3,2) | ab(4,1) | ab(5,0)));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, '0));
        // Illegal output indices never match
        tbl.push_back(mk(0, 6'h3F, PBAD, 6'h3F, 6'h3F, 6'h00, '0));
        tbl.push_back(mk(0, 6'h3F, PBAD, 6'h00, 6'h3F, 6'h00, '0));
        // No credit while idle, then credit arrives
        tbl.push_back(mk(0, 6'h01, pk(3,0,0,0,0,0), 6'h01, 6'h00, 6'h00, '0));
        tbl.push_back(mk(0, 6'h01, pk(3,0,0,0,0,0), 6'h01, 6'h08, 6'h01, '0));
        tbl.push_back(mk(0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, ab(0, 3)));

        reset = 1'b1; reqValid = '0; reqOutPort = '0; reqTail = '0; outReady = '0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[k])
            step($sformatf("row%0d", k), tbl[k].rst, tbl[k].v, tbl[k].p, tbl[k].t, tbl[k].r,
                 tbl[k].g, tbl[k].a);

        // Backpressure: input 3 locked on output 1 (ptr[1]=5), input 4 blocked
        PB = pk(0, 0, 0, 1, 1, 0);
        step("bp_head",   0, 6'h18, PB, 6'h10, 6'h3F, 6'h08, '0);
        step("bp_stall0", 0, 6'h18, PB, 6'h10, 6'h3D, 6'h00, ab(3, 1));
        step("bp_stall1", 0, 6'h18, PB, 6'h10, 6'h3D, 6'h00, '0);
        step("bp_stall2", 0, 6'h18, PB, 6'h10, 6'h3D, 6'h00, '0);
        step("bp_bubble", 0, 6'h10, PB, 6'h10, 6'h3F, 6'h00, '0);
        step("bp_resume", 0, 6'h18, PB, 6'h18, 6'h3F, 6'h08, '0);
        step("bp_next",   0, 6'h10, PB, 6'h10, 6'h3F, 6'h10, ab(3, 1));
        step("bp_idle",   0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, ab(4, 1));

        // Reset while input 1 holds output 0 drops the lock
        PR = pk(0, 0, 0, 0, 0, 0);
        step("rst_head",  0, 6'h12, PR, 6'h10, 6'h3F, 6'h02, '0);
        step("rst_body",  0, 6'h12, PR, 6'h10, 6'h3F, 6'h02, ab(1, 0));
        step("rst_pulse", 1, 6'h12, PR, 6'h10, 6'h3F, 6'h00, ab(1, 0));
        step("rst_after", 0, 6'h10, PR, 6'h10, 6'h3F, 6'h10, '0);
        step("rst_idle",  0, 6'h00, P0, 6'h00, 6'h3F, 6'h00, ab(4, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
